// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-detecting, maskable interrupt controller with req/ack/eoi handshake
module interrupt_controller #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               mask_wr_i,
    input  logic [NUM_SRC-1:0] mask_data_i,
    input  logic               ack_i,
    input  logic               eoi_i,
    output logic               interrupt_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic               in_service_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;

    state_t             state_q, state_d;
    logic               interrupt_q, interrupt_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] prev_src_q;

    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] eligible;
    logic               any_eligible;
    logic [ID_W-1:0]    lowest_id;

    assign evt          = irq_src_i & ~prev_src_q;
    assign eligible     = pending_q & mask_q;
    assign any_eligible = |eligible;

    // Priority pick: scanning downwards leaves the lowest set index as the winner
    always_comb begin
        lowest_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lowest_id = ID_W'(i);
            end
        end
    end

    // State register; prev_src tracks the raw inputs during reset so held-high lines do not fire on release
    always_ff @(posedge clk_i) begin
        prev_src_q <= irq_src_i;
        if (rst_i) begin
            state_q     <= ST_IDLE;
            interrupt_q <= 1'b0;
            irq_id_q    <= '0;
            pending_q   <= '0;
            mask_q      <= '1;
        end else begin
            state_q     <= state_d;
            interrupt_q <= interrupt_d;
            irq_id_q    <= irq_id_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
        end
    end

    // Next-state: events always latch; the handshake FSM picks, holds, clears and waits for eoi
    always_comb begin
        state_d     = state_q;
        interrupt_d = interrupt_q;
        irq_id_d    = irq_id_q;
        pending_d   = pending_q | evt;
        mask_d      = mask_wr_i ? mask_data_i : mask_q;

        case (state_q)
            ST_IDLE: begin
                if (any_eligible) begin
                    irq_id_d    = lowest_id;
                    interrupt_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_i) begin
                    interrupt_d         = 1'b0;
                    // A fresh edge on the acknowledged source in this same cycle survives the clear
                    pending_d[irq_id_q] = evt[irq_id_q];
                    state_d             = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                interrupt_d = 1'b0;
                if (eoi_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                interrupt_d = 1'b0;
            end
        endcase
    end

    assign interrupt_o  = interrupt_q;
    assign irq_id_o     = irq_id_q;
    assign pending_o    = pending_q;
    assign in_service_o = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - self-checking bench for interrupt_controller
module tb_interrupt_controller;

    logic       clk;
    logic       rst;
    logic [3:0] irq_src;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       ack;
    logic       eoi;
    logic       interrupt;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic       in_service;

    int cmp_cnt = 0;
    int err_cnt = 0;

    interrupt_controller #(.NUM_SRC(4), .ID_W(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .irq_src_i    (irq_src),
        .mask_wr_i    (mask_wr),
        .mask_data_i  (mask_data),
        .ack_i        (ack),
        .eoi_i        (eoi),
        .interrupt_o  (interrupt),
        .irq_id_o     (irq_id),
        .pending_o    (pending),
        .in_service_o (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a "phase" (0 waiting, 1 requesting, 2 servicing) plus per-source flags
    int m_phase;
    bit m_int;
    int m_id;
    bit m_pend [4];
    bit m_mask [4];
    bit m_prev [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic [3:0] src, input bit mwr, input logic [3:0] mdata,
                              input bit a, input bit e, input bit r);
        bit rise [4];
        int pick;
        pick = -1;
        if (r) begin
            m_phase = 0; m_int = 0; m_id = 0;
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0; m_mask[i] = 1; m_prev[i] = src[i];
            end
            return;
        end
        for (int i = 0; i < 4; i++) rise[i] = src[i] && !m_prev[i];
        for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) pick = i;
        if (m_phase == 0 && pick >= 0) begin
            m_phase = 1; m_int = 1; m_id = pick;
        end else if (m_phase == 1 && a) begin
            m_phase = 2; m_int = 0; m_pend[m_id] = 0;
        end else if (m_phase == 2 && e) begin
            m_phase = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (rise[i]) m_pend[i] = 1;
            if (mwr) m_mask[i] = mdata[i];
            m_prev[i] = src[i];
        end
    endtask

    task automatic test_reset();
        rst = 1; irq_src = 4'b0010; mask_wr = 0; mask_data = 4'b1111; ack = 0; eoi = 0;
        tick(); tick();
        cmp_cnt++;
        if (interrupt !== 1'b0 || irq_id !== 2'd0 || pending !== 4'b0000 || in_service !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: int=%b id=%0d pend=%b svc=%b, required 0/0/0000/0",
                     interrupt, irq_id, pending, in_service);
        end
        rst = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            cmp_cnt++;
            if (interrupt !== 1'b0 || pending !== 4'b0000) begin
                err_cnt++;
                $display("FAIL reset_release_quiet cyc%0d: int=%b pend=%b, required 0/0000", c, interrupt, pending);
            end
        end
    endtask

    task automatic test_basic_request();
        irq_src = 4'b0110;
        tick();
        cmp_cnt++;
        if (pending !== 4'b0100 || interrupt !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_latch: pend=%b int=%b, required 0100/0", pending, interrupt);
        end
        tick();
        cmp_cnt++;
        if (interrupt !== 1'b1 || irq_id !== 2'd2) begin
            err_cnt++;
            $display("FAIL basic_assert: int=%b id=%0d, required 1/2", interrupt, irq_id);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            cmp_cnt++;
            if (interrupt !== 1'b1 || irq_id !== 2'd2 || in_service !== 1'b0) begin
                err_cnt++;
                $display("FAIL basic_hold cyc%0d: int=%b id=%0d svc=%b, required 1/2/0", c, interrupt, irq_id, in_service);
            end
        end
        ack = 1;
        tick();
        ack = 0;
        cmp_cnt++;
        if (interrupt !== 1'b0 || pending !== 4'b0000 || in_service !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_ack: int=%b pend=%b svc=%b, required 0/0000/1", interrupt, pending, in_service);
        end
        eoi = 1;
        tick();
        eoi = 0;
        tick();
        cmp_cnt++;
        if (in_service !== 1'b0 || interrupt !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_eoi: svc=%b int=%b, required 0/0", in_service, interrupt);
        end
    endtask

    task automatic test_priority();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b1010;
        tick();
        tick();
        cmp_cnt++;
        if (interrupt !== 1'b1 || irq_id !== 2'd1 || pending !== 4'b1010) begin
            err_cnt++;
            $display("FAIL prio_first: int=%b id=%0d pend=%b, required 1/1/1010", interrupt, irq_id, pending);
        end
        ack = 1; tick(); ack = 0;
        eoi = 1; tick(); eoi = 0;
        tick();
        cmp_cnt++;
        if (interrupt !== 1'b1 || irq_id !== 2'd3 || pending !== 4'b1000) begin
            err_cnt++;
            $display("FAIL prio_second: int=%b id=%0d pend=%b, required 1/3/1000", interrupt, irq_id, pending);
        end
        ack = 1; tick(); ack = 0;
        eoi = 1; tick(); eoi = 0;
    endtask

    task automatic test_mask();
        irq_src = 4'b0000;
        tick();
        mask_wr = 1; mask_data = 4'b1110;
        tick();
        mask_wr = 0;
        irq_src = 4'b0001;
        tick();
        for (int c = 0; c < 3; c++) tick();
        cmp_cnt++;
        if (pending !== 4'b0001 || interrupt !== 1'b0) begin
            err_cnt++;
            $display("FAIL mask_block: pend=%b int=%b, required 0001/0", pending, interrupt);
        end
        mask_wr = 1; mask_data = 4'b1111;
        tick();
        mask_wr = 0;
        cmp_cnt++;
        if (interrupt !== 1'b0) begin
            err_cnt++;
            $display("FAIL mask_load_edge: int=%b, required 0", interrupt);
        end
        tick();
        cmp_cnt++;
        if (interrupt !== 1'b1 || irq_id !== 2'd0) begin
            err_cnt++;
            $display("FAIL mask_unblock: int=%b id=%0d, required 1/0", interrupt, irq_id);
        end
        ack = 1; tick(); ack = 0;
        eoi = 1; tick(); eoi = 0;
    endtask

    task automatic test_service_events_and_reset();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0100;
        tick(); tick();
        ack = 1; tick(); ack = 0;
        irq_src = 4'b0110; ack = 1;
        tick();
        ack = 0;
        cmp_cnt++;
        if (pending !== 4'b0010 || in_service !== 1'b1 || interrupt !== 1'b0) begin
            err_cnt++;
            $display("FAIL svc_latch: pend=%b svc=%b int=%b, required 0010/1/0", pending, in_service, interrupt);
        end
        eoi = 1; tick(); eoi = 0;
        tick();
        cmp_cnt++;
        if (interrupt !== 1'b1 || irq_id !== 2'd1) begin
            err_cnt++;
            $display("FAIL svc_reassert: int=%b id=%0d, required 1/1", interrupt, irq_id);
        end
        rst = 1;
        tick();
        rst = 0;
        cmp_cnt++;
        if (interrupt !== 1'b0 || pending !== 4'b0000 || in_service !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_in_req: int=%b pend=%b svc=%b, required 0/0000/0", interrupt, pending, in_service);
        end
    endtask

    task automatic test_set_wins_and_ack_eoi();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0001;
        tick(); tick();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0001; ack = 1; eoi = 1;
        tick();
        ack = 0; eoi = 0;
        cmp_cnt++;
        if (pending !== 4'b0001 || in_service !== 1'b1) begin
            err_cnt++;
            $display("FAIL set_wins_ack_eoi: pend=%b svc=%b, required 0001/1", pending, in_service);
        end
        eoi = 1; tick(); eoi = 0;
        tick();
        cmp_cnt++;
        if (interrupt !== 1'b1 || irq_id !== 2'd0) begin
            err_cnt++;
            $display("FAIL set_wins_reassert: int=%b id=%0d, required 1/0", interrupt, irq_id);
        end
    endtask

    task automatic test_random();
        rst = 1; irq_src = 4'($urandom_range(0, 15)); mask_wr = 0; ack = 0; eoi = 0;
        model_step(irq_src, 0, mask_data, 0, 0, 1);
        tick();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom_range(0, 15));
            mask_wr   = ($urandom_range(0, 9) == 0);
            mask_data = 4'($urandom_range(0, 15));
            ack       = ($urandom_range(0, 2) == 0);
            eoi       = ($urandom_range(0, 2) == 0);
            model_step(irq_src, mask_wr, mask_data, ack, eoi, rst);
            tick();
            cmp_cnt++;
            if (interrupt !== m_int || irq_id !== 2'(m_id) || in_service !== (m_phase == 2) ||
                pending !== {m_pend[3], m_pend[2], m_pend[1], m_pend[0]}) begin
                err_cnt++;
                $display("FAIL random cyc%0d: int=%b id=%0d svc=%b pend=%b, required %b/%0d/%b/%b",
                         c, interrupt, irq_id, in_service, pending, m_int, m_id, (m_phase == 2),
                         {m_pend[3], m_pend[2], m_pend[1], m_pend[0]});
            end
        end
        rst = 0; mask_wr = 0; ack = 0; eoi = 0;
    endtask

    initial begin
        test_reset();
        test_basic_request();
        test_priority();
        test_mask();
        test_service_events_and_reset();
        test_set_wins_and_ack_eoi();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
